// File: rtl/sext_arbiter.sv
// Two-requester round-robin arbiter in front of the shared 4->16 bit sign extender.
// Define SEXT_ARB_FIXED_PRIO_EN to give requester A fixed priority on ties.
module sext_arbiter #(
    parameter int IN_W  = 4,
    parameter int OUT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_a,
    input  logic [IN_W-1:0]  imm_a,
    input  logic             req_b,
    input  logic [IN_W-1:0]  imm_b,
    output logic             gnt_a,
    output logic             gnt_b,
    output logic [IN_W-1:0]  sext_in,
    input  logic [OUT_W-1:0] sext_out,
    output logic [OUT_W-1:0] result,
    output logic             result_valid,
    output logic             result_id,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        RESULT = 2'd2
    } state_e;

    localparam logic OWNER_A = 1'b0;
    localparam logic OWNER_B = 1'b1;

    state_e            state_q, state_d;
    logic [IN_W-1:0]   imm_q, imm_d;
    logic              owner_q, owner_d;
    logic              last_q, last_d;
    logic              gnt_a_q, gnt_a_d;
    logic              gnt_b_q, gnt_b_d;
    logic [OUT_W-1:0]  result_q, result_d;
    logic              result_valid_q, result_valid_d;
    logic              result_id_q, result_id_d;
    logic              busy_q, busy_d;
    logic              win_a_s, win_b_s;

    // Pick the winner among the current requests.
    always_comb begin
        win_a_s = 1'b0;
        win_b_s = 1'b0;
        if (req_a && req_b) begin
`ifdef SEXT_ARB_FIXED_PRIO_EN
            win_a_s = 1'b1;
`else
            // Tie goes to whoever was not served last.
            if (last_q == OWNER_B) begin
                win_a_s = 1'b1;
            end else begin
                win_b_s = 1'b1;
            end
`endif
        end else if (req_a) begin
            win_a_s = 1'b1;
        end else if (req_b) begin
            win_b_s = 1'b1;
        end else begin
            win_a_s = 1'b0;
            win_b_s = 1'b0;
        end
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_d        = state_q;
        imm_d          = imm_q;
        owner_d        = owner_q;
        last_d         = last_q;
        gnt_a_d        = 1'b0;
        gnt_b_d        = 1'b0;
        result_d       = result_q;
        result_valid_d = 1'b0;
        result_id_d    = result_id_q;
        case (state_q)
            IDLE, RESULT: begin
                if (win_a_s) begin
                    imm_d   = imm_a;
                    owner_d = OWNER_A;
                    gnt_a_d = 1'b1;
                    state_d = GRANT;
                end else if (win_b_s) begin
                    imm_d   = imm_b;
                    owner_d = OWNER_B;
                    gnt_b_d = 1'b1;
                    state_d = GRANT;
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT: begin
                // Extender output is combinational on imm_q, stable throughout GRANT.
                result_d       = sext_out;
                result_id_d    = owner_q;
                result_valid_d = 1'b1;
                last_d         = owner_q;
                state_d        = RESULT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            imm_q          <= {IN_W{1'b0}};
            owner_q        <= OWNER_A;
            last_q         <= OWNER_B;
            gnt_a_q        <= 1'b0;
            gnt_b_q        <= 1'b0;
            result_q       <= {OUT_W{1'b0}};
            result_valid_q <= 1'b0;
            result_id_q    <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            imm_q          <= imm_d;
            owner_q        <= owner_d;
            last_q         <= last_d;
            gnt_a_q        <= gnt_a_d;
            gnt_b_q        <= gnt_b_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            result_id_q    <= result_id_d;
            busy_q         <= busy_d;
        end
    end

    assign gnt_a        = gnt_a_q;
    assign gnt_b        = gnt_b_q;
    assign sext_in      = imm_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign result_id    = result_id_q;
    assign busy         = busy_q;

endmodule
